axis_egress_rr_arbiter: RTL and testbench
=========================================

// Module: axis_egress_rr_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter sharing one egress AXI-Stream among NUM_PORTS verified
//  masters (each upstream already tlast/tvalid-corrected by a master verifier). Sits between the
//  per-tenant verifiers and the shared MAC/egress path. Decoupled ports are skipped.
//  Grant is held until the tlast beat completes. The output passes through a 1-deep register slice.
// PARAMETERS
//  NUM_PORTS        4   number of input streams (>=2)
//  AXIS_BUS_WIDTH   64  tdata width, multiple of 8
//  AXIS_ID_WIDTH    4   tid width (>= $clog2(NUM_PORTS) when OVERRIDE_TID=1)
//  AXIS_DEST_WIDTH  4   tdest width
//  OVERRIDE_TID     1   1: axis_m_tid = granted port index (zero-extended); 0: pass source tid through
// PORTS
//  aclk               in   1           clock; all interfaces synchronous
//  aresetn            in   1           reset, asynchronous assert, active-low
//  axis_s_tdata       in   N*W         port i occupies slice [i*W +: W]; tid/tdest/tkeep packed the same way
//  axis_s_tid         in   N*IDW
//  axis_s_tdest       in   N*DW
//  axis_s_tkeep       in   N*W/8
//  axis_s_tlast       in   N
//  axis_s_tvalid      in   N
//  axis_s_tready      out  N           at most one bit high, for the granted port only
//  axis_m_tdata/tid/tdest/tkeep/tlast/tvalid  out  W/IDW/DW/W/8/1/1   shared egress stream
//  axis_m_tready      in   1
//  decouple           in   N           1 = port excluded from new arbitration
//  grant_valid        out  1           a packet is currently granted
//  grant_idx          out  $clog2(N)   index of the granted port (valid when grant_valid=1)
// BEHAVIOUR
//  Reset (async): state=IDLE, grant_valid=0, grant_idx=0, axis_s_tready=0, axis_m_tvalid=0,
//   last_grant=NUM_PORTS-1, so port 0 has top priority after reset. Datapath regs are not reset.
//  req[i] = axis_s_tvalid[i] & ~decouple[i].
//  FSM, 2 states:
//   IDLE: if |req, pick the first set req scanning from (last_grant+1) mod N upward with wrap.
//    Load grant_idx and last_grant; next state XFER. Else stay in IDLE.
//   XFER: axis_s_tready[grant_idx] = slice_ready. On a handshake with tlast=1, next state IDLE.
//  slice_ready = axis_m_tready | ~axis_m_tvalid.
//  Register slice: on an input handshake, load data, tid, tdest, tkeep and tlast; set m_tvalid=1.
//   Otherwise, if axis_m_tready, clear m_tvalid. Latency is 1 cycle input->output.
//  Throughput: one IDLE cycle between packets, so a single-beat packet takes 2 cycles.
//  Mid-packet rules:
//   - decouple asserted: ignored until tlast; takes effect at the next IDLE.
//   - granted tvalid low: tready still offered; the bubble passes and no re-arbitration occurs.
//  Non-granted ports see tready=0 regardless of their tvalid.
//  All ports decoupled or idle: remain in IDLE; grant_valid=0.
//  Simultaneous tlast handshake and new tvalid on other ports: they are considered next IDLE cycle.
//  Reset mid-packet: packet truncated at output, no partial replay. Downstream sees m_tvalid drop.
// STRUCTURE
//  Package axis_arb_pkg holds:
//   - typedef enum logic {ARB_IDLE, ARB_XFER} arb_state_t;
//   - function clog2_min1(n) giving index width >=1.
//  Sub-module rr_priority_picker #(N): in {req[N], last[$clog2 N]}, out {any, idx}.
//   Purely combinational rotate, priority-encode, unrotate.
//  Top holds the FSM, the grant mux (indexed part-selects) and the output register slice.
// TESTING
//  1. Reset with tvalid=4'b1111, each port sending 1-beat packets, m_tready=1.
//     Required grant order 0,1,2,3,0; output tid=0,1,2,3,0; one packet per 2 cycles.
//  2. Port 2 sends a 5-beat packet; port 0 asserts tvalid at beat 2.
//     All 5 port-2 beats are contiguous at output; port 0 is granted afterwards; s_tready[0]=0 meanwhile.
//  3. decouple=4'b0010, all ports valid. Port 1 is never granted; order 0,2,3,0.
//     Assert decouple[3] during port 3's packet: that packet completes and port 3 is skipped thereafter.
//  4. m_tready toggled 1,0,0,1 during a 4-beat packet.
//     No data is lost or duplicated; m_tdata is stable while m_tvalid & ~m_tready.
//  5. Assert aresetn=0 asynchronously mid-packet on port 1.
//     m_tvalid=0 and s_tready=0 immediately; the first grant after release goes to port 0.
//  6. Granted port drops tvalid for 3 cycles mid-packet while port 3 is valid.
//     Grant is retained; port 3 is not served until the tlast beat.

Source files
------------

// File: rtl/axis_egress_rr_arbiter_pkg.sv
// Shared types and helpers for the egress round-robin arbiter.
package axis_arb_pkg;

  // Arbiter control states: waiting for a request, or streaming one packet.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_t;

  // Index width that never collapses to zero bits, even for tiny port counts.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_egress_rr_arbiter_if.sv
// Bundled AXI-Stream lanes. LANES streams are packed side by side: lane i
// uses slice [i*W +: W] of tdata and the matching slices of the side-band.
interface axis_egress_rr_arbiter_if #(
  parameter int LANES = 1,
  parameter int W     = 64,
  parameter int IDW   = 4,
  parameter int DW    = 4
);
  logic [LANES*W-1:0]     tdata;
  logic [LANES*IDW-1:0]   tid;
  logic [LANES*DW-1:0]    tdest;
  logic [LANES*W/8-1:0]   tkeep;
  logic [LANES-1:0]       tlast;
  logic [LANES-1:0]       tvalid;
  logic [LANES-1:0]       tready;

  modport master (
    output tdata, tid, tdest, tkeep, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tid, tdest, tkeep, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/axis_egress_rr_arbiter_rr_priority_picker.sv
// Round-robin picker: finds the first requesting port strictly after `last`,
// wrapping around. Rotate so the search starts at bit 0, take the lowest set
// bit, then rotate the index back into port numbering.
module rr_priority_picker
  import axis_arb_pkg::*;
#(
  parameter int  N  = 4,
  localparam int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [IW-1:0]  start;
  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] req_shift;
  logic [N-1:0]   req_rot;
  logic [IW-1:0]  enc;
  logic [IW:0]    sum;

  assign start     = (last >= IW'(N - 1)) ? '0 : last + 1'b1;
  assign req_dbl   = {req, req};
  assign req_shift = req_dbl >> start;
  assign req_rot   = req_shift[N-1:0];
  assign any       = |req;

  // Lowest set bit of the rotated request vector wins.
  always_comb begin
    enc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        enc = IW'(i);
      end
    end
  end

  // Undo the rotation: (enc + start) mod N without a divider.
  always_comb begin
    sum = {1'b0, enc} + {1'b0, start};
    if (sum >= (IW + 1)'(N)) begin
      idx = IW'(sum - (IW + 1)'(N));
    end else begin
      idx = sum[IW-1:0];
    end
  end

endmodule

// File: rtl/axis_egress_rr_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_PORTS AXI-Stream masters
// onto one egress stream through a 1-deep output register slice. A grant is
// held from the first beat through the tlast beat; one idle cycle separates
// packets so the picker always sees settled requests.
module axis_egress_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int  NUM_PORTS       = 4,
  parameter int  AXIS_BUS_WIDTH  = 64,
  parameter int  AXIS_ID_WIDTH   = 4,
  parameter int  AXIS_DEST_WIDTH = 4,
  parameter int  OVERRIDE_TID    = 1,
  localparam int IW              = clog2_min1(NUM_PORTS),
  localparam int KW              = AXIS_BUS_WIDTH / 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  axis_egress_rr_arbiter_if.slave   axis_s,
  axis_egress_rr_arbiter_if.master  axis_m,
  input  logic [NUM_PORTS-1:0]      decouple,
  output logic                      grant_valid,
  output logic [IW-1:0]             grant_idx
);

  arb_state_t state_reg, state_next;
  logic [IW-1:0] grant_idx_reg;
  logic [IW-1:0] last_grant_reg;
  logic          load_grant;

  logic [NUM_PORTS-1:0] req;
  logic                 pick_any;
  logic [IW-1:0]        pick_idx;

  logic [AXIS_BUS_WIDTH-1:0]  sel_tdata;
  logic [AXIS_ID_WIDTH-1:0]   sel_tid;
  logic [AXIS_DEST_WIDTH-1:0] sel_tdest;
  logic [KW-1:0]              sel_tkeep;
  logic                       sel_tlast;
  logic                       sel_tvalid;
  logic [AXIS_ID_WIDTH-1:0]   out_tid;

  logic                       slice_ready;
  logic                       s_hs;
  logic [NUM_PORTS-1:0]       tready_vec;

  logic [AXIS_BUS_WIDTH-1:0]  m_tdata_reg;
  logic [AXIS_ID_WIDTH-1:0]   m_tid_reg;
  logic [AXIS_DEST_WIDTH-1:0] m_tdest_reg;
  logic [KW-1:0]              m_tkeep_reg;
  logic                       m_tlast_reg;
  logic                       m_tvalid_reg;

  // Decoupled ports never enter arbitration; an ongoing grant ignores decouple.
  assign req = axis_s.tvalid & ~decouple;

  rr_priority_picker #(.N(NUM_PORTS)) u_picker (
    .req  (req),
    .last (last_grant_reg),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Grant mux: select the granted lane out of the packed input buses.
  assign sel_tdata  = axis_s.tdata[int'(grant_idx_reg)*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
  assign sel_tid    = axis_s.tid[int'(grant_idx_reg)*AXIS_ID_WIDTH +: AXIS_ID_WIDTH];
  assign sel_tdest  = axis_s.tdest[int'(grant_idx_reg)*AXIS_DEST_WIDTH +: AXIS_DEST_WIDTH];
  assign sel_tkeep  = axis_s.tkeep[int'(grant_idx_reg)*KW +: KW];
  assign sel_tlast  = axis_s.tlast[grant_idx_reg];
  assign sel_tvalid = axis_s.tvalid[grant_idx_reg];

  generate
    if (OVERRIDE_TID != 0) begin : g_tid_override
      assign out_tid = AXIS_ID_WIDTH'(grant_idx_reg);
    end else begin : g_tid_pass
      assign out_tid = sel_tid;
    end
  endgenerate

  // The slice accepts whenever it is empty or being drained this cycle.
  assign slice_ready = axis_m.tready[0] | ~m_tvalid_reg;
  assign s_hs        = (state_reg == ARB_XFER) & sel_tvalid & slice_ready;

  // Only the granted port sees tready; it is offered even while its tvalid is low.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_tready
      assign tready_vec[gi] = (state_reg == ARB_XFER) &&
                              (grant_idx_reg == IW'(gi)) && slice_ready;
    end
  endgenerate
  assign axis_s.tready = tready_vec;

  // Next-state logic: pick in IDLE, release the grant after the tlast handshake.
  always_comb begin
    state_next = state_reg;
    load_grant = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        if (pick_any) begin
          load_grant = 1'b1;
          state_next = ARB_XFER;
        end
      end
      ARB_XFER: begin
        if (s_hs && sel_tlast) begin
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // State and grant registers; last_grant starts at the top port so port 0 wins first.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg      <= ARB_IDLE;
      grant_idx_reg  <= '0;
      last_grant_reg <= IW'(NUM_PORTS - 1);
    end else begin
      state_reg <= state_next;
      if (load_grant) begin
        grant_idx_reg  <= pick_idx;
        last_grant_reg <= pick_idx;
      end
    end
  end

  // Output valid flag: set on an accepted beat, cleared once downstream takes it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tvalid_reg <= 1'b0;
    end else if (s_hs) begin
      m_tvalid_reg <= 1'b1;
    end else if (axis_m.tready[0]) begin
      m_tvalid_reg <= 1'b0;
    end
  end

  // Output payload: captured on each accepted beat, otherwise held stable.
  always_ff @(posedge aclk) begin
    if (s_hs) begin
      m_tdata_reg <= sel_tdata;
      m_tid_reg   <= out_tid;
      m_tdest_reg <= sel_tdest;
      m_tkeep_reg <= sel_tkeep;
      m_tlast_reg <= sel_tlast;
    end
  end

  assign axis_m.tdata  = m_tdata_reg;
  assign axis_m.tid    = m_tid_reg;
  assign axis_m.tdest  = m_tdest_reg;
  assign axis_m.tkeep  = m_tkeep_reg;
  assign axis_m.tlast  = m_tlast_reg;
  assign axis_m.tvalid = m_tvalid_reg;

  assign grant_valid = (state_reg == ARB_XFER);
  assign grant_idx   = grant_idx_reg;

endmodule

// File: tb/tb_axis_egress_rr_arbiter.sv
// Scoreboard bench for the egress round-robin arbiter: tests queue the
// expected egress beats in hand-worked order, a monitor pops and compares
// every beat the DUT delivers.
module tb_axis_egress_rr_arbiter;

  localparam int N   = 4;
  localparam int W   = 64;
  localparam int IDW = 4;
  localparam int DW  = 4;
  localparam int KW  = W / 8;

  typedef struct {
    logic [W-1:0]   data;
    logic [IDW-1:0] tid;
    logic [DW-1:0]  dest;
    logic [KW-1:0]  keep;
    logic           last;
    int             gap;
  } beat_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axis_egress_rr_arbiter_if #(.LANES(N), .W(W), .IDW(IDW), .DW(DW)) s_if ();
  axis_egress_rr_arbiter_if #(.LANES(1), .W(W), .IDW(IDW), .DW(DW)) m_if ();

  logic [N-1:0] decouple;
  logic         grant_valid;
  logic [1:0]   grant_idx;

  axis_egress_rr_arbiter #(
    .NUM_PORTS(N), .AXIS_BUS_WIDTH(W), .AXIS_ID_WIDTH(IDW),
    .AXIS_DEST_WIDTH(DW), .OVERRIDE_TID(1)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .axis_s      (s_if),
    .axis_m      (m_if),
    .decouple    (decouple),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  beat_t        port_q[N][$];
  beat_t        exp_q[$];
  logic [N-1:0] hold;
  logic [N-1:0] dec_next;
  logic         mtr_next;
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Source beats carry a foreign tid (12+port) so the override is visible.
  function automatic beat_t mk(input int port, input int pkt, input int idx,
                               input bit last, input int gap, input bit as_out);
    beat_t b;
    b.data = {8'(port), 8'(pkt), 8'(idx), 40'h5A5A5A5A5A};
    b.tid  = as_out ? IDW'(port) : IDW'(12 + port);
    b.dest = DW'(port * 3 + 1);
    b.keep = last ? 8'h0F : 8'hFF;
    b.last = last;
    b.gap  = gap;
    return b;
  endfunction

  task automatic add_pkt(input int port, input int pkt, input int nbeats);
    for (int k = 0; k < nbeats; k++)
      port_q[port].push_back(mk(port, pkt, k, (k == nbeats - 1), -1, 1'b0));
  endtask

  task automatic expect_beat(input int port, input int pkt, input int idx,
                             input bit last, input int gap);
    exp_q.push_back(mk(port, pkt, idx, last, gap, 1'b1));
  endtask

  task automatic drive();
    beat_t b;
    for (int i = 0; i < N; i++) begin
      if (port_q[i].size() > 0 && !hold[i]) begin
        b = port_q[i][0];
        s_if.tvalid[i]            = 1'b1;
        s_if.tdata[i*W +: W]      = b.data;
        s_if.tid[i*IDW +: IDW]    = b.tid;
        s_if.tdest[i*DW +: DW]    = b.dest;
        s_if.tkeep[i*KW +: KW]    = b.keep;
        s_if.tlast[i]             = b.last;
      end else begin
        s_if.tvalid[i] = 1'b0;
        s_if.tlast[i]  = 1'b0;
      end
    end
    decouple      = dec_next;
    m_if.tready[0] = mtr_next;
  endtask

  task automatic sample();
    chk("tready_onehot0", 64'($countones(s_if.tready) <= 1), 64'(1));
    for (int i = 0; i < N; i++)
      if (s_if.tvalid[i] && s_if.tready[i]) void'(port_q[i].pop_front());
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
    drive();
    @(negedge aclk);
    sample();
  endtask

  task automatic wait_drain(input int limit);
    for (int k = 0; k < limit && exp_q.size() > 0; k++) tick();
    chk("drain_pending_beats", 64'(exp_q.size()), 64'(0));
    repeat (3) tick();
  endtask

  task automatic pulse_reset();
    aresetn = 1'b0;
    repeat (2) tick();
    aresetn = 1'b1;
  endtask

  // Monitor: compares each delivered beat, its spacing, and stall stability.
  initial begin : monitor
    int    neg_cnt;
    int    last_out;
    logic  stall_prev;
    logic [W-1:0] stall_data;
    beat_t e;
    neg_cnt = 0;
    last_out = 0;
    stall_prev = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge aclk);
      neg_cnt++;
      if (stall_prev) begin
        chk("stall_valid_held", 64'(m_if.tvalid[0]), 64'(1));
        chk("stall_data_held", m_if.tdata, stall_data);
      end
      if (m_if.tvalid[0] && m_if.tready[0]) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got data %h, expected no beat", m_if.tdata);
        end else begin
          e = exp_q.pop_front();
          chk("out_tdata", m_if.tdata, e.data);
          chk("out_tid", 64'(m_if.tid), 64'(e.tid));
          chk("out_tdest_tkeep_tlast", 64'({m_if.tdest, m_if.tkeep, m_if.tlast}),
              64'({e.dest, e.keep, e.last}));
          if (e.gap >= 0) chk("out_beat_spacing", 64'(neg_cnt - last_out), 64'(e.gap));
        end
        last_out = neg_cnt;
      end
      stall_prev = aresetn && m_if.tvalid[0] && !m_if.tready[0];
      stall_data = m_if.tdata;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit found;
    s_if.tdata = '0; s_if.tid = '0; s_if.tdest = '0; s_if.tkeep = '0;
    s_if.tlast = '0; s_if.tvalid = '0;
    hold = '0; dec_next = '0; mtr_next = 1'b1;
    drive();

    // Test 1: all ports valid from reset, single-beat packets.
    add_pkt(0, 0, 1); add_pkt(1, 0, 1); add_pkt(2, 0, 1); add_pkt(3, 0, 1);
    add_pkt(0, 1, 1);
    repeat (2) tick();
    chk("reset_grant_valid", 64'(grant_valid), 64'(0));
    chk("reset_grant_idx", 64'(grant_idx), 64'(0));
    chk("reset_m_tvalid", 64'(m_if.tvalid), 64'(0));
    chk("reset_s_tready", 64'(s_if.tready), 64'(0));
    expect_beat(0, 0, 0, 1, -1);
    expect_beat(1, 0, 0, 1, 2);
    expect_beat(2, 0, 0, 1, 2);
    expect_beat(3, 0, 0, 1, 2);
    expect_beat(0, 1, 0, 1, 2);
    aresetn = 1'b1;
    wait_drain(60);

    // Test 2: 5-beat packet on port 2; port 0 arrives mid-packet and must wait.
    add_pkt(2, 0, 5);
    expect_beat(2, 0, 0, 0, -1);
    for (int k = 1; k < 5; k++) expect_beat(2, 0, k, (k == 4), 1);
    expect_beat(0, 2, 0, 1, 2);
    repeat (2) tick();
    add_pkt(0, 2, 1);
    repeat (3) begin
      tick();
      chk("t2_port0_tready", 64'(s_if.tready[0]), 64'(0));
      chk("t2_grant_idx", 64'(grant_idx), 64'(2));
      chk("t2_grant_valid", 64'(grant_valid), 64'(1));
    end
    wait_drain(60);

    // Test 3: port 1 decoupled; port 3 decoupled while its packet is in flight.
    dec_next = 4'b0010;
    aresetn = 1'b0;
    add_pkt(0, 3, 1); add_pkt(1, 3, 1); add_pkt(2, 3, 1); add_pkt(3, 3, 3);
    add_pkt(0, 4, 1); add_pkt(3, 4, 1);
    expect_beat(0, 3, 0, 1, -1);
    expect_beat(2, 3, 0, 1, 2);
    expect_beat(3, 3, 0, 0, 2);
    expect_beat(3, 3, 1, 0, 1);
    expect_beat(3, 3, 2, 1, 1);
    expect_beat(0, 4, 0, 1, 2);
    repeat (2) tick();
    aresetn = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (grant_valid && grant_idx == 2'd3) found = 1'b1;
    end
    chk("t3_port3_granted", 64'(found), 64'(1));
    dec_next = 4'b1010;
    wait_drain(60);
    repeat (5) tick();
    chk("t3_port1_never_served", 64'(port_q[1].size()), 64'(1));
    chk("t3_port3_skipped", 64'(port_q[3].size()), 64'(1));
    chk("t3_idle_grant_valid", 64'(grant_valid), 64'(0));
    port_q[1].delete(); port_q[3].delete();
    dec_next = '0;
    tick();

    // Test 4: downstream backpressure 1,0,0,1 during a 4-beat packet.
    add_pkt(2, 5, 4);
    for (int k = 0; k < 4; k++) expect_beat(2, 5, k, (k == 3), -1);
    repeat (2) tick();
    mtr_next = 1'b1; tick();
    mtr_next = 1'b0; tick();
    mtr_next = 1'b0; tick();
    mtr_next = 1'b1;
    wait_drain(60);

    // Test 5: asynchronous reset in the middle of a port 1 packet.
    add_pkt(1, 6, 6);
    expect_beat(1, 6, 0, 0, -1);
    expect_beat(1, 6, 1, 0, 1);
    repeat (4) tick();
    #2;
    aresetn = 1'b0;
    #1;
    chk("t5_async_m_tvalid", 64'(m_if.tvalid), 64'(0));
    chk("t5_async_s_tready", 64'(s_if.tready), 64'(0));
    chk("t5_async_grant_valid", 64'(grant_valid), 64'(0));
    for (int i = 0; i < N; i++) port_q[i].delete();
    repeat (2) tick();
    aresetn = 1'b1;
    for (int i = 0; i < N; i++) add_pkt(i, 7, 1);
    expect_beat(0, 7, 0, 1, -1);
    expect_beat(1, 7, 0, 1, 2);
    expect_beat(2, 7, 0, 1, 2);
    expect_beat(3, 7, 0, 1, 2);
    wait_drain(60);

    // Test 6: granted port 1 stalls its tvalid for 3 cycles while port 3 waits.
    add_pkt(1, 8, 4);
    expect_beat(1, 8, 0, 0, -1);
    expect_beat(1, 8, 1, 0, 1);
    expect_beat(1, 8, 2, 0, -1);
    expect_beat(1, 8, 3, 1, 1);
    expect_beat(3, 8, 0, 1, 2);
    repeat (2) tick();
    add_pkt(3, 8, 1);
    tick();
    hold[1] = 1'b1;
    repeat (3) begin
      tick();
      chk("t6_grant_retained", 64'({grant_valid, grant_idx}), 64'({1'b1, 2'd1}));
      chk("t6_port3_tready", 64'(s_if.tready[3]), 64'(0));
      chk("t6_port1_tready_offered", 64'(s_if.tready[1]), 64'(1));
    end
    hold[1] = 1'b0;
    wait_drain(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
